// File: rtl/mem_addr_queue.sv
// mem_addr_queue: in-order memory-op queue that issues ready ops to the AGU and drains addresses in program order
module mem_addr_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic                     alloc_is_store,
  input  logic                     alloc_a_rdy,
  input  logic [TAG_W-1:0]         alloc_a_tag,
  input  logic [XLEN-1:0]          alloc_a_data,
  input  logic [XLEN-1:0]          alloc_imm,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  output logic                     agu_valid,
  output logic [TAG_W-1:0]         agu_tag,
  output logic [XLEN-1:0]          agu_a,
  output logic [XLEN-1:0]          agu_b,
  input  logic                     agu_res_valid,
  input  logic [TAG_W-1:0]         agu_res_tag,
  input  logic [XLEN-1:0]          agu_res_addr,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [TAG_W-1:0]         mem_tag,
  output logic                     mem_is_store,
  output logic [XLEN-1:0]          mem_addr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0] r_valid, r_st, r_ardy, r_iss, r_done;
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [TAG_W-1:0] r_atag [DEPTH];
  logic [XLEN-1:0]  r_a [DEPTH];
  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [XLEN-1:0]  r_addr [DEPTH];
  logic [AW-1:0]    r_head, r_tail, w_sel, w_idx;
  logic [CW-1:0]    r_count;
  logic             w_found, w_alloc, w_drain, w_alloc_wake;

  assign alloc_ready  = r_count != CW'(DEPTH);
  assign w_alloc      = alloc_valid && alloc_ready;
  assign w_drain      = mem_valid && mem_ready;
  assign w_alloc_wake = !alloc_a_rdy && cdb_valid && (cdb_tag == alloc_a_tag);
  assign agu_valid    = w_found;
  assign agu_tag      = w_found ? r_tag[w_sel] : '0;
  assign agu_a        = w_found ? r_a[w_sel] : '0;
  assign agu_b        = w_found ? r_imm[w_sel] : '0;
  assign mem_valid    = r_valid[r_head] && r_done[r_head];
  assign mem_tag      = mem_valid ? r_tag[r_head] : '0;
  assign mem_is_store = mem_valid && r_st[r_head];
  assign mem_addr     = mem_valid ? r_addr[r_head] : '0;
  assign count        = r_count;

  // Oldest-first issue select: scan youngest to oldest so the oldest eligible entry wins
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_head;
    w_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_idx = r_head + AW'(i);
      if (r_valid[w_idx] && r_ardy[w_idx] && !r_iss[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Entry state, pointers and occupancy; flush overrides every same-cycle update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_st    <= '0;
      r_ardy  <= '0;
      r_iss   <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_atag[i] <= '0;
        r_a[i]    <= '0;
        r_imm[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && !r_ardy[i] && cdb_valid && r_atag[i] == cdb_tag) begin
          r_ardy[i] <= 1'b1;
          r_a[i]    <= cdb_data;
        end
        if (w_found && w_sel == AW'(i)) r_iss[i] <= 1'b1;
        if (agu_res_valid && r_valid[i] && r_iss[i] && r_tag[i] == agu_res_tag) begin
          r_done[i] <= 1'b1;
          r_addr[i] <= agu_res_addr;
        end
        if (w_drain && r_head == AW'(i)) r_valid[i] <= 1'b0;
        if (w_alloc && r_tail == AW'(i)) begin
          r_valid[i] <= 1'b1;
          r_st[i]    <= alloc_is_store;
          r_tag[i]   <= alloc_tag;
          r_ardy[i]  <= alloc_a_rdy || w_alloc_wake;
          r_atag[i]  <= alloc_a_tag;
          r_a[i]     <= alloc_a_rdy ? alloc_a_data : cdb_data;
          r_imm[i]   <= alloc_imm;
          r_iss[i]   <= 1'b0;
          r_done[i]  <= 1'b0;
          r_addr[i]  <= '0;
        end
      end
      if (w_alloc) r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
    end
  end
endmodule
